// File: rtl/eth_perf_pkg.sv
// Shared types and constants for the performance-counter event master.
// Command offsets are word offsets within one section's slot of the counter map.
package eth_perf_pkg;

    localparam int          NUM_SECTIONS = 4;
    localparam logic [3:0]  CMD_STOP_OFS = 4'd0;
    localparam logic [3:0]  CMD_GO_OFS   = 4'd1;
    localparam logic [31:0] CLEAR_DATA   = 32'h1;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_CLEAR,
        CMD_GO,
        CMD_STOP
    } cmd_e;

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        oh2idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) oh2idx = 2'(i);
        end
    endfunction

endpackage

// File: rtl/eth_perf_rr_arb.sv
// Four-way round-robin arbiter: one-hot grant, combinational from requests.
// Pointer moves past the granted requester only when accept_i is high.
module eth_perf_rr_arb (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req_i,
    input  logic       accept_i,
    output logic [3:0] gnt_o
);

    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx;
    logic [1:0] gidx;
    logic       found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = ptr_q;
        gidx  = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gidx       = idx;
                found      = 1'b1;
            end
        end
    end

    assign ptr_d = (accept_i && found) ? gidx + 2'd1 : ptr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= 2'd0;
        else          ptr_q <= ptr_d;
    end

endmodule

// File: rtl/eth_perf_event_master.sv
// Turns per-section start/stop/clear events into one-cycle Avalon-MM writes.
// Event-to-write latency 2 cycles; at most one write every 2 cycles, excess events set drop_sticky.
module eth_perf_event_master
    import eth_perf_pkg::*;
#(
    parameter int NUM_SECTIONS = eth_perf_pkg::NUM_SECTIONS,
    parameter int BASE_STRIDE  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  start_evt,
    input  logic [3:0]  stop_evt,
    input  logic        clear_req,
    input  logic        enable,
    output logic [3:0]  address,
    output logic        write,
    output logic        begintransfer,
    output logic [31:0] writedata,
    output logic [3:0]  running,
    output logic [3:0]  drop_sticky,
    output logic        busy
);

    state_e      state_q, state_d;
    cmd_e        cmd_q, cmd_d;
    logic [1:0]  sec_q, sec_d;
    logic [3:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  go_q, go_d, stop_q, stop_d;
    logic [3:0]  run_q, run_d, drop_q, drop_d, gofirst_q, gofirst_d;
    logic        clr_q, clr_d;

    logic [3:0]  req, gnt;
    logic        accept;
    logic [1:0]  gsec;
    logic        issue_clr;
    logic [3:0]  iss_go, iss_stop;
    logic [3:0]  go_keep, stop_keep, go_pend, stop_pend, run_cur;
    logic [3:0]  start_ok, stop_ok, drops;

    assign req  = go_q | stop_q;
    assign gsec = oh2idx(gnt);

    eth_perf_rr_arb u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_i    (req),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_NONE;
            sec_q   <= 2'd0;
            addr_q  <= 4'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            sec_q   <= sec_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Command is chosen and latched on the IDLE->ISSUE edge; clear always wins.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        sec_d   = sec_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_q) begin
                    state_d = ST_ISSUE;
                    cmd_d   = CMD_CLEAR;
                    addr_d  = 4'd0;
                    wdata_d = CLEAR_DATA;
                end else if (|req) begin
                    state_d = ST_ISSUE;
                    accept  = 1'b1;
                    sec_d   = gsec;
                    wdata_d = 32'd0;
                    if (go_q[gsec] && (!stop_q[gsec] || gofirst_q[gsec])) begin
                        cmd_d  = CMD_GO;
                        addr_d = 4'(int'(gsec) * BASE_STRIDE) + CMD_GO_OFS;
                    end else begin
                        cmd_d  = CMD_STOP;
                        addr_d = 4'(int'(gsec) * BASE_STRIDE) + CMD_STOP_OFS;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        write         = (state_q == ST_ISSUE);
        begintransfer = (state_q == ST_ISSUE);
        address       = addr_q;
        writedata     = wdata_q;
        running       = run_q;
        drop_sticky   = drop_q;
        busy          = (state_q == ST_ISSUE) || (|go_q) || (|stop_q) || clr_q;
    end

    assign issue_clr = (state_q == ST_ISSUE) && (cmd_q == CMD_CLEAR);
    assign iss_go    = ((state_q == ST_ISSUE) && (cmd_q == CMD_GO))   ? (4'b0001 << sec_q) : 4'b0000;
    assign iss_stop  = ((state_q == ST_ISSUE) && (cmd_q == CMD_STOP)) ? (4'b0001 << sec_q) : 4'b0000;

    // Events are judged against the state as it stands once this cycle's command retires,
    // except that a flag re-armed in its own issue cycle is never a drop.
    always_comb begin
        go_keep   = '0;
        stop_keep = '0;
        go_pend   = '0;
        stop_pend = '0;
        run_cur   = '0;
        start_ok  = '0;
        stop_ok   = '0;
        drops     = '0;
        go_d      = '0;
        stop_d    = '0;
        run_d     = '0;
        gofirst_d = gofirst_q;
        for (int i = 0; i < NUM_SECTIONS; i++) begin
            go_keep[i]   = !issue_clr && go_q[i] && !iss_go[i];
            stop_keep[i] = !issue_clr && stop_q[i] && !iss_stop[i];
            go_pend[i]   = !issue_clr && go_q[i];
            stop_pend[i] = !issue_clr && stop_q[i];
            run_cur[i]   = !issue_clr && run_q[i];
            start_ok[i]  = enable && start_evt[i] && !go_keep[i] && !(run_cur[i] && !stop_pend[i]);
            stop_ok[i]   = enable && stop_evt[i] && !stop_keep[i]
                           && (run_cur[i] || go_pend[i] || start_ok[i]);
            drops[i]     = (enable && start_evt[i] && !start_ok[i])
                           || (enable && stop_evt[i] && !stop_ok[i]);
            go_d[i]      = go_keep[i] || start_ok[i];
            stop_d[i]    = stop_keep[i] || stop_ok[i];
            run_d[i]     = iss_go[i] || (run_cur[i] && !iss_stop[i]);
            if (start_ok[i] && !stop_keep[i])     gofirst_d[i] = 1'b1;
            else if (stop_ok[i] && !go_keep[i])   gofirst_d[i] = 1'b0;
        end
        drop_d = (issue_clr ? 4'b0000 : drop_q) | drops;
    end

    assign clr_d = (clr_q && !issue_clr) || (enable && clear_req);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            go_q      <= '0;
            stop_q    <= '0;
            run_q     <= '0;
            drop_q    <= '0;
            gofirst_q <= '0;
            clr_q     <= 1'b0;
        end else begin
            go_q      <= go_d;
            stop_q    <= stop_d;
            run_q     <= run_d;
            drop_q    <= drop_d;
            gofirst_q <= gofirst_d;
            clr_q     <= clr_d;
        end
    end

endmodule

// File: tb/tb_eth_perf_event_master.sv
// Cycle table of directed events with hand-computed outputs, plus a mid-write reset sequence.
module tb_eth_perf_event_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  start_evt, stop_evt;
    logic        clear_req, enable;
    logic [3:0]  address;
    logic        write, begintransfer;
    logic [31:0] writedata;
    logic [3:0]  running, drop_sticky;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    eth_perf_event_master #(.NUM_SECTIONS(4), .BASE_STRIDE(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start_evt     (start_evt),
        .stop_evt      (stop_evt),
        .clear_req     (clear_req),
        .enable        (enable),
        .address       (address),
        .write         (write),
        .begintransfer (begintransfer),
        .writedata     (writedata),
        .running       (running),
        .drop_sticky   (drop_sticky),
        .busy          (busy)
    );

    typedef struct {
        logic [3:0]  st;
        logic [3:0]  sp;
        logic        clr;
        logic        en;
        logic        ew;
        logic [3:0]  ea;
        logic [31:0] ed;
        logic [3:0]  er;
        logic [3:0]  edr;
        logic        eb;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [3:0] st, input logic [3:0] sp, input logic clr, input logic en,
                       input logic ew, input logic [3:0] ea, input logic [31:0] ed,
                       input logic [3:0] er, input logic [3:0] edr, input logic eb);
        vec_t v;
        v.st = st; v.sp = sp; v.clr = clr; v.en = en;
        v.ew = ew; v.ea = ea; v.ed = ed; v.er = er; v.edr = edr; v.eb = eb;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; start_evt = '0; stop_evt = '0; clear_req = 1'b0; enable = 1'b1;

        // Rows: inputs held for one cycle, then outputs just after the edge that samples them.
        //  start   stop    clr  en   write addr  data  running drop   busy
        // All four sections at once: round-robin 1,5,9,13 every other cycle.
        add(4'hF, 4'h0, 0, 1,  0, 0,  0, 4'h0, 4'h0, 1);
        add(4'h0, 4'h0, 0, 1,  1, 1,  0, 4'h0, 4'h0, 1);
        add(4'h0, 4'h0, 0, 1,  0, 0,  0, 4'h1, 4'h0, 1);
        add(4'h0, 4'h0, 0, 1,  1, 5,  0, 4'h1, 4'h0, 1);
        add(4'h0, 4'h0, 0, 1,  0, 0,  0, 4'h3, 4'h0, 1);
        add(4'h0, 4'h0, 0, 1,  1, 9,  0, 4'h3, 4'h0, 1);
        add(4'h0, 4'h0, 0, 1,  0, 0,  0, 4'h7, 4'h0, 1);
        add(4'h0, 4'h0, 0, 1,  1, 13, 0, 4'h7, 4'h0, 1);
        add(4'h0, 4'h0, 0, 1,  0, 0,  0, 4'hF, 4'h0, 0);
        // Restart of a running section is dropped, twice, no write.
        add(4'h8, 4'h0, 0, 1,  0, 0,  0, 4'hF, 4'h8, 0);
        add(4'h8, 4'h0, 0, 1,  0, 0,  0, 4'hF, 4'h8, 0);
        add(4'h0, 4'h0, 0, 1,  0, 0,  0, 4'hF, 4'h8, 0);
        // Clear: address 0, data 1; drops and running wiped after the write.
        add(4'h0, 4'h0, 1, 1,  0, 0,  0, 4'hF, 4'h8, 1);
        add(4'h0, 4'h0, 0, 1,  1, 0,  1, 4'hF, 4'h8, 1);
        add(4'h0, 4'h0, 0, 1,  0, 0,  0, 4'h0, 4'h0, 0);
        // Clear together with GO_2: only the clear is written.
        add(4'h4, 4'h0, 1, 1,  0, 0,  0, 4'h0, 4'h0, 1);
        add(4'h0, 4'h0, 0, 1,  1, 0,  1, 4'h0, 4'h0, 1);
        add(4'h0, 4'h0, 0, 1,  0, 0,  0, 4'h0, 4'h0, 0);
        add(4'h0, 4'h0, 0, 1,  0, 0,  0, 4'h0, 4'h0, 0);
        // Start and stop of section 1 together: GO (5) then STOP (4).
        add(4'h2, 4'h2, 0, 1,  0, 0,  0, 4'h0, 4'h0, 1);
        add(4'h0, 4'h0, 0, 1,  1, 5,  0, 4'h0, 4'h0, 1);
        add(4'h0, 4'h0, 0, 1,  0, 0,  0, 4'h2, 4'h0, 1);
        add(4'h0, 4'h0, 0, 1,  1, 4,  0, 4'h2, 4'h0, 1);
        add(4'h0, 4'h0, 0, 1,  0, 0,  0, 4'h0, 4'h0, 0);
        // Disabled events are ignored; stop of an idle section is a drop.
        add(4'h1, 4'h0, 0, 0,  0, 0,  0, 4'h0, 4'h0, 0);
        add(4'h0, 4'h1, 0, 1,  0, 0,  0, 4'h0, 4'h1, 0);
        // Section 3 running, STOP_3 set before GO_3 while section 0 holds the bus: STOP first.
        add(4'h8, 4'h0, 0, 1,  0, 0,  0, 4'h0, 4'h1, 1);
        add(4'h0, 4'h0, 0, 1,  1, 13, 0, 4'h0, 4'h1, 1);
        add(4'h0, 4'h0, 0, 1,  0, 0,  0, 4'h8, 4'h1, 0);
        add(4'h1, 4'h8, 0, 1,  0, 0,  0, 4'h8, 4'h1, 1);
        add(4'h8, 4'h0, 0, 1,  1, 1,  0, 4'h8, 4'h1, 1);
        add(4'h0, 4'h0, 0, 1,  0, 0,  0, 4'h9, 4'h1, 1);
        add(4'h0, 4'h0, 0, 1,  1, 12, 0, 4'h9, 4'h1, 1);
        add(4'h0, 4'h0, 0, 1,  0, 0,  0, 4'h1, 4'h1, 1);
        add(4'h0, 4'h0, 0, 1,  1, 13, 0, 4'h1, 4'h1, 1);
        add(4'h0, 4'h0, 0, 1,  0, 0,  0, 4'h9, 4'h1, 0);

        #23;
        chk("reset_write", {31'd0, write}, 32'd0);
        chk("reset_bt", {31'd0, begintransfer}, 32'd0);
        chk("reset_addr", {28'd0, address}, 32'd0);
        chk("reset_wdata", writedata, 32'd0);
        chk("reset_running", {28'd0, running}, 32'd0);
        chk("reset_drop", {28'd0, drop_sticky}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        @(negedge clk);
        reset_n = 1'b1;
        tick();

        for (int r = 0; r < vq.size(); r++) begin
            start_evt = vq[r].st;
            stop_evt  = vq[r].sp;
            clear_req = vq[r].clr;
            enable    = vq[r].en;
            tick();
            start_evt = '0; stop_evt = '0; clear_req = 1'b0; enable = 1'b1;
            chk($sformatf("row%0d_write", r), {31'd0, write}, {31'd0, vq[r].ew});
            chk($sformatf("row%0d_bt", r), {31'd0, begintransfer}, {31'd0, vq[r].ew});
            if (vq[r].ew) begin
                chk($sformatf("row%0d_addr", r), {28'd0, address}, {28'd0, vq[r].ea});
                chk($sformatf("row%0d_wdata", r), writedata, vq[r].ed);
            end
            chk($sformatf("row%0d_running", r), {28'd0, running}, {28'd0, vq[r].er});
            chk($sformatf("row%0d_drop", r), {28'd0, drop_sticky}, {28'd0, vq[r].edr});
            chk($sformatf("row%0d_busy", r), {31'd0, busy}, {31'd0, vq[r].eb});
        end

        // Reset landing in the middle of a write cycle.
        start_evt = 4'h2;
        tick();
        start_evt = '0;
        tick();
        chk("rst_pre_write", {31'd0, write}, 32'd1);
        chk("rst_pre_addr", {28'd0, address}, 32'd5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_write", {31'd0, write}, 32'd0);
        chk("rst_async_bt", {31'd0, begintransfer}, 32'd0);
        chk("rst_async_addr", {28'd0, address}, 32'd0);
        chk("rst_async_running", {28'd0, running}, 32'd0);
        chk("rst_async_drop", {28'd0, drop_sticky}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("rst_after%0d_write", c), {31'd0, write}, 32'd0);
            chk($sformatf("rst_after%0d_busy", c), {31'd0, busy}, 32'd0);
            chk($sformatf("rst_after%0d_running", c), {28'd0, running}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
